obb_sat_engine: RTL and testbench
=================================

# obb_sat_engine

Multi-cycle separating-axis-theorem (SAT) engine for one pair of oriented bounding boxes (OBBs). It is the parametrised, sequential successor to the combinational collision detector. Given two boxes (centre, full extents, unit axis vectors u/v), it returns a collision flag, the first separating axis, and the minimum penetration depth with its axis. It sits between the physics state RAM and the collision-response logic, under a start/busy/done handshake.

## Interface
- POS_W, 32: width of signed position, Q(POS_W-POS_FRAC).POS_FRAC.
- POS_FRAC, 24: fractional bits of positions and of `penetration`.
- VEC_W, 16: width of signed axis-vector components.
- VEC_FRAC, 14: fractional bits of axis vectors (0x4000 = 1.0).
- DIM_W, 8: width of unsigned integer full extents.
- EARLY_EXIT, 1: 1 = stop at the first separating axis; 0 = always test all 4 axes.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- widthA, heightA, widthB, heightB  in  DIM_W  full extents along u / v.
- posA_x, posA_y, posB_x, posB_y  in  POS_W  centres, signed.
- uA_x, uA_y, vA_x, vA_y, uB_x, uB_y, vB_x, vB_y  in  VEC_W  unit axes, signed.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- is_collision  out  1  1 = no separating axis found.
- sep_axis  out  2  first separating axis index (0=uA, 1=vA, 2=uB, 3=vB); 0 if colliding.
- penetration  out  POS_W+2  signed min overlap over tested axes, Q.POS_FRAC.
- min_axis  out  2  axis index giving `penetration`.

## Operation
- States: IDLE, MUL, SCALE, CMP, DONE. Axis counter k = 0..3; axis L_k selected from latched uA, vA, uB, vB.
- IDLE: when start=1, latch all inputs, set k=0, clear the running minimum to the most-positive value, and go to MUL. Inputs are don't-care after latch.
- MUL: form 10 products. They are dx·Lx and dy·Ly, where dx = posB_x−posA_x and dy = posB_y−posA_y, each POS_W+1 bits. The rest are the u·L and v·L component products for both boxes. Arithmetic-shift each by VEC_FRAC, rounding toward −inf.
- SCALE: absolute-value the 4 axis projections and the distance.
  - r = (width·|u·L| + height·|v·L|), arithmetic-shifted so the result is Q.POS_FRAC of half-extent, i.e. extent·2^(POS_FRAC−1).
  - overlap_k = rA + rB − |d·L|, in an internal width of POS_W+4, truncated to POS_W+2 on output.
- CMP:
  - If overlap_k < 0: record sep_axis=k if this is the first separating axis.
  - If overlap_k < running min: update min and min_axis. Ties keep the lower index.
  - Then go to MUL with k+1, unless k=3 or (EARLY_EXIT and separation found), in which case go to DONE.
- Touching boxes (overlap = 0) count as colliding.
- DONE: drive the result registers, pulse done, return to IDLE.
- Results hold until the next DONE.
- start while busy is ignored, with no queueing.
- start in the same cycle as a done pulse is also ignored: the FSM is in DONE, not IDLE.
- Reset at any time:
  - State goes to IDLE.
  - busy=0, done=0, is_collision=0, sep_axis=0, penetration=0, min_axis=0.
  - An in-flight result is discarded.

## Timing
- start sampled at edge 0. busy=1 from edge 1.
- For axis k: MUL at cycle 3k+1, SCALE at 3k+2, CMP at 3k+3.
- Full run: done=1 during cycle 13, then busy=0 in the same cycle as done. Latency is 13 cycles.
- Early exit at axis k: done during cycle 3k+4.
- Earliest re-accepted start is the cycle after done. Throughput is ≤ 1 pair per 14 cycles.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Separated, axis-aligned (all u=(0x4000,0), v=(0,0x4000), 10×10): A=(14,14), B=(40,14), EARLY_EXIT=1 -> done at cycle 4, is_collision=0, sep_axis=0, penetration=−16.0 (0x...F0000000 sign-extended), min_axis=0.
- Touching: B=(24,14) -> done at cycle 13, is_collision=1, penetration=0, min_axis=0.
- Overlapping: B=(20,13) -> is_collision=1, penetration=4.0 (0x04000000), min_axis=0. The y-axis overlap is 9.0.
- Rotated B: u=(0x2D41,0x2D41), v=(−0x2D41,0x2D41), B=(26,14) -> is_collision=1, min_axis=0, penetration≈0.07 (±2^−12).
- Negative coordinates and EARLY_EXIT=0:
  - B=(−12,14) -> is_collision=0, sep_axis=0, done at cycle 13.
  - The same case with EARLY_EXIT=1 -> done at cycle 4.
- Control:
  - start held high for 30 cycles -> exactly 2 done pulses, 14 cycles apart.
  - Reset_n low at cycle 6 -> all outputs 0 immediately, no done pulse.
  - Next start after release completes normally.

Source files
------------

// File: rtl/obb_sat_engine.sv
// Sequential separating-axis test for one pair of oriented bounding boxes.
// Each of the four candidate axes (uA, vA, uB, vB) takes three cycles:
// MUL (projections), SCALE (radii and overlap) and CMP (running min / separation).
module obb_sat_engine #(
    parameter int unsigned POS_W      = 32,
    parameter int unsigned POS_FRAC   = 24,
    parameter int unsigned VEC_W      = 16,
    parameter int unsigned VEC_FRAC   = 14,
    parameter int unsigned DIM_W      = 8,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    start,
    input  logic [DIM_W-1:0]        widthA,
    input  logic [DIM_W-1:0]        heightA,
    input  logic [DIM_W-1:0]        widthB,
    input  logic [DIM_W-1:0]        heightB,
    input  logic signed [POS_W-1:0] posA_x,
    input  logic signed [POS_W-1:0] posA_y,
    input  logic signed [POS_W-1:0] posB_x,
    input  logic signed [POS_W-1:0] posB_y,
    input  logic signed [VEC_W-1:0] uA_x,
    input  logic signed [VEC_W-1:0] uA_y,
    input  logic signed [VEC_W-1:0] vA_x,
    input  logic signed [VEC_W-1:0] vA_y,
    input  logic signed [VEC_W-1:0] uB_x,
    input  logic signed [VEC_W-1:0] uB_y,
    input  logic signed [VEC_W-1:0] vB_x,
    input  logic signed [VEC_W-1:0] vB_y,
    output logic                    busy,
    output logic                    done,
    output logic                    is_collision,
    output logic [1:0]              sep_axis,
    output logic signed [POS_W+1:0] penetration,
    output logic [1:0]              min_axis
);

    localparam int unsigned DW  = POS_W + 1;                 // centre difference
    localparam int unsigned PW  = POS_W + 4;                 // internal overlap width
    localparam int unsigned DPW = DW + VEC_W;                // d * L product
    localparam int unsigned APW = 2 * VEC_W;                 // axis * axis product
    localparam int unsigned PJW = 2 * VEC_W - VEC_FRAC + 2;  // axis-on-axis projection sum
    // Extent * |proj| is in Q.VEC_FRAC of full extent; radius wants Q.POS_FRAC of half.
    localparam int unsigned SHL = (POS_FRAC - 1 >= VEC_FRAC) ? POS_FRAC - 1 - VEC_FRAC : 0;
    localparam int unsigned SHR = (POS_FRAC - 1 >= VEC_FRAC) ? 0 : VEC_FRAC + 1 - POS_FRAC;
    localparam logic signed [PW-1:0] MinInit = {1'b0, {(PW - 1){1'b1}}};

    typedef enum logic [2:0] {StIdle, StMul, StScale, StCmp, StDone} state_e;

    state_e                  state_q;
    logic [1:0]              k_q;
    logic signed [DW-1:0]    dx_q, dy_q;
    logic [DIM_W-1:0]        dim_q [4];   // widthA, heightA, widthB, heightB
    logic signed [VEC_W-1:0] ax_q  [4];   // uA, vA, uB, vB x-components
    logic signed [VEC_W-1:0] ay_q  [4];   // uA, vA, uB, vB y-components

    logic signed [VEC_W-1:0] lx, ly;
    logic signed [DPW-1:0]   dxl, dyl;
    logic signed [APW-1:0]   axl [4], ayl [4];
    logic signed [PW-1:0]    dl_d, dl_q;
    logic signed [PJW-1:0]   proj_d [4], proj_q [4];

    logic [PJW-1:0]          ap   [4];
    logic [PW-1:0]           term [4];
    logic [PW-1:0]           ra, rb, adl;
    logic signed [PW-1:0]    ov_d, ov_q;

    logic                    sep_found_q, sep_found_d;
    logic [1:0]              sep_k_q, sep_k_d;
    logic signed [PW-1:0]    min_q, min_d;
    logic [1:0]              min_k_q, min_k_d;
    logic                    last;

    // MUL: project centre difference and all four box axes onto axis L_k
    always_comb begin
        lx   = ax_q[k_q];
        ly   = ay_q[k_q];
        dxl  = (DPW'(dx_q) * DPW'(lx)) >>> VEC_FRAC;
        dyl  = (DPW'(dy_q) * DPW'(ly)) >>> VEC_FRAC;
        dl_d = PW'(dxl) + PW'(dyl);
        for (int i = 0; i < 4; i++) begin
            axl[i]    = (APW'(ax_q[i]) * APW'(lx)) >>> VEC_FRAC;
            ayl[i]    = (APW'(ay_q[i]) * APW'(ly)) >>> VEC_FRAC;
            proj_d[i] = PJW'(axl[i]) + PJW'(ayl[i]);
        end
    end

    // SCALE: radii of both boxes on L_k and the resulting overlap
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ap[i]   = proj_q[i][PJW-1] ? $unsigned(-proj_q[i]) : $unsigned(proj_q[i]);
            term[i] = PW'(dim_q[i]) * PW'(ap[i]);
        end
        ra   = ((term[0] + term[1]) << SHL) >> SHR;
        rb   = ((term[2] + term[3]) << SHL) >> SHR;
        adl  = dl_q[PW-1] ? $unsigned(-dl_q) : $unsigned(dl_q);
        ov_d = $signed(ra + rb - adl);
    end

    // CMP: first separating axis, running minimum (ties keep lower index), exit decision
    always_comb begin
        sep_found_d = sep_found_q | ov_q[PW-1];
        sep_k_d     = sep_found_q ? sep_k_q : k_q;
        min_d       = min_q;
        min_k_d     = min_k_q;
        if (ov_q < min_q) begin
            min_d   = ov_q;
            min_k_d = k_q;
        end
        last = (k_q == 2'd3) || ((EARLY_EXIT != 0) && sep_found_d);
    end

    // Datapath registers: input latch, per-axis projections and overlap
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
            dl_q <= '0;
            ov_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dim_q[i]  <= '0;
                ax_q[i]   <= '0;
                ay_q[i]   <= '0;
                proj_q[i] <= '0;
            end
        end else begin
            if (state_q == StIdle && start) begin
                dx_q     <= DW'(posB_x) - DW'(posA_x);
                dy_q     <= DW'(posB_y) - DW'(posA_y);
                dim_q[0] <= widthA;
                dim_q[1] <= heightA;
                dim_q[2] <= widthB;
                dim_q[3] <= heightB;
                ax_q[0]  <= uA_x;
                ay_q[0]  <= uA_y;
                ax_q[1]  <= vA_x;
                ay_q[1]  <= vA_y;
                ax_q[2]  <= uB_x;
                ay_q[2]  <= uB_y;
                ax_q[3]  <= vB_x;
                ay_q[3]  <= vB_y;
            end
            if (state_q == StMul) begin
                dl_q <= dl_d;
                for (int i = 0; i < 4; i++) begin
                    proj_q[i] <= proj_d[i];
                end
            end
            if (state_q == StScale) begin
                ov_q <= ov_d;
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            k_q          <= 2'd0;
            sep_found_q  <= 1'b0;
            sep_k_q      <= 2'd0;
            min_q        <= MinInit;
            min_k_q      <= 2'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            is_collision <= 1'b0;
            sep_axis     <= 2'd0;
            penetration  <= '0;
            min_axis     <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StMul;
                        busy        <= 1'b1;
                        k_q         <= 2'd0;
                        sep_found_q <= 1'b0;
                        sep_k_q     <= 2'd0;
                        min_q       <= MinInit;
                        min_k_q     <= 2'd0;
                    end
                end
                StMul:   state_q <= StScale;
                StScale: state_q <= StCmp;
                StCmp: begin
                    sep_found_q <= sep_found_d;
                    sep_k_q     <= sep_k_d;
                    min_q       <= min_d;
                    min_k_q     <= min_k_d;
                    if (last) begin
                        // Results go out on entry to DONE so done and data align
                        state_q      <= StDone;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        is_collision <= ~sep_found_d;
                        sep_axis     <= sep_found_d ? sep_k_d : 2'd0;
                        penetration  <= min_d[POS_W+1:0];
                        min_axis     <= min_k_d;
                    end else begin
                        state_q <= StMul;
                        k_q     <= k_q + 2'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_obb_sat_engine.sv
// Directed bench for obb_sat_engine: two instances (early exit on / off) share stimulus.
module tb_obb_sat_engine;

    logic               Clk;
    logic               Reset_n;
    logic               start;
    logic [7:0]         widthA, heightA, widthB, heightB;
    logic signed [31:0] posA_x, posA_y, posB_x, posB_y;
    logic signed [15:0] uA_x, uA_y, vA_x, vA_y, uB_x, uB_y, vB_x, vB_y;

    logic               busy_e, done_e, coll_e, busy_f, done_f, coll_f;
    logic [1:0]         sep_e, min_e, sep_f, min_f;
    logic signed [33:0] pen_e, pen_f;

    int n_checks = 0;
    int n_fail   = 0;

    // Values captured at each instance's done pulse
    int                 c_cyc_e, c_cyc_f;
    logic               c_coll_e, c_coll_f, c_busy_e, c_busy_f;
    logic [1:0]         c_sep_e, c_sep_f, c_min_e, c_min_f;
    logic signed [33:0] c_pen_e, c_pen_f;

    localparam logic signed [33:0] PenM16 = -34'sd268435456;  // -16.0
    localparam logic signed [33:0] Pen4   = 34'sd67108864;    //   4.0

    obb_sat_engine #(.EARLY_EXIT(1)) dut_e (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .widthA(widthA), .heightA(heightA), .widthB(widthB), .heightB(heightB),
        .posA_x(posA_x), .posA_y(posA_y), .posB_x(posB_x), .posB_y(posB_y),
        .uA_x(uA_x), .uA_y(uA_y), .vA_x(vA_x), .vA_y(vA_y),
        .uB_x(uB_x), .uB_y(uB_y), .vB_x(vB_x), .vB_y(vB_y),
        .busy(busy_e), .done(done_e), .is_collision(coll_e),
        .sep_axis(sep_e), .penetration(pen_e), .min_axis(min_e)
    );

    obb_sat_engine #(.EARLY_EXIT(0)) dut_f (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .widthA(widthA), .heightA(heightA), .widthB(widthB), .heightB(heightB),
        .posA_x(posA_x), .posA_y(posA_y), .posB_x(posB_x), .posB_y(posB_y),
        .uA_x(uA_x), .uA_y(uA_y), .vA_x(vA_x), .vA_y(vA_y),
        .uB_x(uB_x), .uB_y(uB_y), .vB_x(vB_x), .vB_y(vB_y),
        .busy(busy_f), .done(done_f), .is_collision(coll_f),
        .sep_axis(sep_f), .penetration(pen_f), .min_axis(min_f)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Box B at integer centre (bx, by); rot selects the 45-degree orientation
    task automatic set_b(input int bx, input int by, input bit rot);
        posB_x = bx <<< 24;
        posB_y = by <<< 24;
        if (rot) begin
            uB_x = 16'sh2D41;  uB_y = 16'sh2D41;
            vB_x = -16'sh2D41; vB_y = 16'sh2D41;
        end else begin
            uB_x = 16'sh4000;  uB_y = 16'sh0000;
            vB_x = 16'sh0000;  vB_y = 16'sh4000;
        end
    endtask

    // Pulse start, then wait (bounded) for done on both instances and capture results
    task automatic run_pair();
        int  n;
        bit  got_e, got_f;
        got_e = 1'b0;
        got_f = 1'b0;
        c_cyc_e = 0;
        c_cyc_f = 0;
        n = 0;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        while (!(got_e && got_f) && n < 40) begin
            @(posedge Clk); #1;
            n++;
            if (!got_e && done_e) begin
                got_e = 1'b1; c_cyc_e = n + 1; c_coll_e = coll_e; c_sep_e = sep_e;
                c_pen_e = pen_e; c_min_e = min_e; c_busy_e = busy_e;
            end
            if (!got_f && done_f) begin
                got_f = 1'b1; c_cyc_f = n + 1; c_coll_f = coll_f; c_sep_f = sep_f;
                c_pen_f = pen_f; c_min_f = min_f; c_busy_f = busy_f;
            end
        end
        n_checks++;
        if (!(got_e && got_f)) begin
            n_fail++;
            $display("FAIL run_timeout: done_e seen %0d done_f seen %0d, want both 1", got_e, got_f);
        end
        @(posedge Clk); #1;  // leave DONE so the next start is accepted
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy_e, done_e, coll_e, sep_e, min_e} !== 7'd0 || pen_e !== 34'sd0) begin
            n_fail++;
            $display("FAIL reset_e: got busy=%0d done=%0d coll=%0d sep=%0d pen=%0h min=%0d, want all 0",
                     busy_e, done_e, coll_e, sep_e, pen_e, min_e);
        end
        n_checks++;
        if ({busy_f, done_f, coll_f, sep_f, min_f} !== 7'd0 || pen_f !== 34'sd0) begin
            n_fail++;
            $display("FAIL reset_f: got busy=%0d done=%0d coll=%0d sep=%0d pen=%0h min=%0d, want all 0",
                     busy_f, done_f, coll_f, sep_f, pen_f, min_f);
        end
    endtask

    task automatic test_separated();
        set_b(40, 14, 1'b0);
        run_pair();
        n_checks++; if (c_cyc_e !== 4) begin n_fail++;
            $display("FAIL sep_cycle_e: got %0d want 4", c_cyc_e); end
        n_checks++; if (c_cyc_f !== 13) begin n_fail++;
            $display("FAIL sep_cycle_f: got %0d want 13", c_cyc_f); end
        n_checks++; if (c_coll_e !== 1'b0 || c_coll_f !== 1'b0) begin n_fail++;
            $display("FAIL sep_coll: got e=%0d f=%0d want 0", c_coll_e, c_coll_f); end
        n_checks++; if (c_sep_e !== 2'd0 || c_sep_f !== 2'd0) begin n_fail++;
            $display("FAIL sep_axis: got e=%0d f=%0d want 0", c_sep_e, c_sep_f); end
        n_checks++; if (c_pen_e !== PenM16 || c_pen_f !== PenM16) begin n_fail++;
            $display("FAIL sep_pen: got e=%0h f=%0h want %0h", c_pen_e, c_pen_f, PenM16); end
        n_checks++; if (c_min_e !== 2'd0 || c_min_f !== 2'd0) begin n_fail++;
            $display("FAIL sep_min: got e=%0d f=%0d want 0", c_min_e, c_min_f); end
    endtask

    task automatic test_touching();
        set_b(24, 14, 1'b0);
        run_pair();
        n_checks++; if (c_cyc_e !== 13 || c_cyc_f !== 13) begin n_fail++;
            $display("FAIL touch_cycle: got e=%0d f=%0d want 13", c_cyc_e, c_cyc_f); end
        n_checks++; if (c_coll_e !== 1'b1 || c_coll_f !== 1'b1) begin n_fail++;
            $display("FAIL touch_coll: got e=%0d f=%0d want 1", c_coll_e, c_coll_f); end
        n_checks++; if (c_pen_e !== 34'sd0 || c_pen_f !== 34'sd0) begin n_fail++;
            $display("FAIL touch_pen: got e=%0h f=%0h want 0", c_pen_e, c_pen_f); end
        n_checks++; if (c_min_e !== 2'd0 || c_sep_e !== 2'd0) begin n_fail++;
            $display("FAIL touch_min_sep: got min=%0d sep=%0d want 0 0", c_min_e, c_sep_e); end
        n_checks++; if (c_busy_e !== 1'b0 || c_busy_f !== 1'b0) begin n_fail++;
            $display("FAIL touch_busy_at_done: got e=%0d f=%0d want 0", c_busy_e, c_busy_f); end
    endtask

    task automatic test_overlap();
        set_b(20, 13, 1'b0);
        run_pair();
        n_checks++; if (c_coll_e !== 1'b1 || c_coll_f !== 1'b1) begin n_fail++;
            $display("FAIL ovl_coll: got e=%0d f=%0d want 1", c_coll_e, c_coll_f); end
        n_checks++; if (c_pen_e !== Pen4 || c_pen_f !== Pen4) begin n_fail++;
            $display("FAIL ovl_pen: got e=%0h f=%0h want %0h", c_pen_e, c_pen_f, Pen4); end
        n_checks++; if (c_min_e !== 2'd0 || c_min_f !== 2'd0) begin n_fail++;
            $display("FAIL ovl_min: got e=%0d f=%0d want 0", c_min_e, c_min_f); end
    endtask

    task automatic test_sep_axis1();
        set_b(14, 40, 1'b0);
        run_pair();
        n_checks++; if (c_cyc_e !== 7 || c_cyc_f !== 13) begin n_fail++;
            $display("FAIL ax1_cycle: got e=%0d f=%0d want 7 13", c_cyc_e, c_cyc_f); end
        n_checks++; if (c_sep_e !== 2'd1 || c_sep_f !== 2'd1) begin n_fail++;
            $display("FAIL ax1_sep: got e=%0d f=%0d want 1", c_sep_e, c_sep_f); end
        n_checks++; if (c_min_e !== 2'd1 || c_min_f !== 2'd1) begin n_fail++;
            $display("FAIL ax1_min: got e=%0d f=%0d want 1", c_min_e, c_min_f); end
        n_checks++; if (c_pen_e !== PenM16 || c_coll_f !== 1'b0) begin n_fail++;
            $display("FAIL ax1_pen_coll: got pen=%0h coll=%0d want %0h 0", c_pen_e, c_coll_f, PenM16); end
    endtask

    // Ideal 5+5*sqrt(2)-12 = 0.0710678 -> 1192316 in Q.24, tolerance 2^-12 = 4096
    task automatic test_rotated();
        set_b(26, 14, 1'b1);
        run_pair();
        set_b(26, 14, 1'b0);
        n_checks++; if (c_coll_e !== 1'b1 || c_coll_f !== 1'b1) begin n_fail++;
            $display("FAIL rot_coll: got e=%0d f=%0d want 1", c_coll_e, c_coll_f); end
        n_checks++; if (c_min_e !== 2'd0 || c_min_f !== 2'd0) begin n_fail++;
            $display("FAIL rot_min: got e=%0d f=%0d want 0", c_min_e, c_min_f); end
        n_checks++; if (c_pen_e < 34'sd1188220 || c_pen_e > 34'sd1196412) begin n_fail++;
            $display("FAIL rot_pen: got %0d want 1192316 +/- 4096", c_pen_e); end
    endtask

    task automatic test_negative();
        set_b(-12, 14, 1'b0);
        run_pair();
        n_checks++; if (c_cyc_e !== 4 || c_cyc_f !== 13) begin n_fail++;
            $display("FAIL neg_cycle: got e=%0d f=%0d want 4 13", c_cyc_e, c_cyc_f); end
        n_checks++; if (c_coll_e !== 1'b0 || c_coll_f !== 1'b0) begin n_fail++;
            $display("FAIL neg_coll: got e=%0d f=%0d want 0", c_coll_e, c_coll_f); end
        n_checks++; if (c_sep_f !== 2'd0 || c_pen_f !== PenM16 || c_min_f !== 2'd0) begin n_fail++;
            $display("FAIL neg_result_f: got sep=%0d pen=%0h min=%0d want 0 %0h 0",
                     c_sep_f, c_pen_f, c_min_f, PenM16); end
    endtask

    // start held high: accepted at edges 0, 14, 28; done samples at 12 and 26 in the window
    task automatic test_back_to_back();
        int pulses, first, second, n;
        set_b(20, 13, 1'b0);
        pulses = 0;
        first  = -1;
        second = -1;
        start  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clk); #1;
            if (done_e) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        start = 1'b0;
        n_checks++; if (pulses !== 2) begin n_fail++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses); end
        n_checks++; if (first !== 12) begin n_fail++;
            $display("FAIL b2b_first: got %0d want 12", first); end
        n_checks++; if (second - first !== 14) begin n_fail++;
            $display("FAIL b2b_spacing: got %0d want 14", second - first); end
        n = 0;
        while (!done_e && n < 20) begin
            @(posedge Clk); #1;
            n++;
        end
        n_checks++; if (done_e !== 1'b1 || n !== 11) begin n_fail++;
            $display("FAIL b2b_third: got done=%0d after %0d cycles want 1 after 11", done_e, n); end
        @(posedge Clk); #1;
    endtask

    // Outputs hold the previous overlap result (coll=1, pen=4.0) before reset hits
    task automatic test_reset_midrun();
        int pulses;
        set_b(24, 14, 1'b0);
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        test_reset();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            if (done_e || done_f) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++;
            $display("FAIL rst_no_done: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_after_reset();
        set_b(20, 13, 1'b0);
        run_pair();
        n_checks++; if (c_cyc_e !== 13 || c_cyc_f !== 13) begin n_fail++;
            $display("FAIL post_rst_cycle: got e=%0d f=%0d want 13", c_cyc_e, c_cyc_f); end
        n_checks++; if (c_coll_e !== 1'b1 || c_pen_e !== Pen4 || c_min_e !== 2'd0) begin n_fail++;
            $display("FAIL post_rst_result: got coll=%0d pen=%0h min=%0d want 1 %0h 0",
                     c_coll_e, c_pen_e, c_min_e, Pen4); end
    endtask

    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        widthA  = 8'd10; heightA = 8'd10; widthB = 8'd10; heightB = 8'd10;
        posA_x  = 32'sd14 <<< 24;
        posA_y  = 32'sd14 <<< 24;
        uA_x = 16'sh4000; uA_y = 16'sh0000;
        vA_x = 16'sh0000; vA_y = 16'sh4000;
        set_b(40, 14, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        test_separated();
        test_touching();
        test_overlap();
        test_sep_axis1();
        test_rotated();
        test_negative();
        test_back_to_back();
        test_reset_midrun();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
